stopwatch_ctrl: RTL and testbench

- Control-side producer of the stopwatch status consumed by the LED driver.
- Converts one-cycle button pulses and a count-enable tick into:
  - a 4-digit BCD mm:ss counter `q`,
  - the status flags `is_pause`, `is_restart` and `is_lap`,
  - a lap-frozen display value.
- Sits between the debounce/one-pulse front end and the LED and seven-segment output blocks.

---
 rtl/stopwatch_ctrl_pkg.sv | 34 +++
 rtl/stopwatch_ctrl_bcd_digit_counter.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 127 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants, state encoding and flag decode for the stopwatch controller.
package stopwatch_ctrl_pkg;

  localparam int BCD_COUNTER_BITS = 16;
  localparam logic [BCD_COUNTER_BITS-1:0] BCD_COUNTER_LIMIT = 16'h5959;
  localparam int LEDS_NUM = 16;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic is_restart;
    logic is_pause;
  } flags_t;

  // Status flags seen by the LED driver for a given state.
  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f = '{is_restart: 1'b0, is_pause: 1'b0};
    unique case (s)
      STATE_IDLE:  f = '{is_restart: 1'b0, is_pause: 1'b0};
      STATE_RUN:   f = '{is_restart: 1'b1, is_pause: 1'b0};
      STATE_PAUSE: f = '{is_restart: 1'b1, is_pause: 1'b1};
      STATE_DONE:  f = '{is_restart: 1'b1, is_pause: 1'b1};
      default:     f = '{is_restart: 1'b0, is_pause: 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit that counts 0..MAX_DIGIT; carry flags the wrap back to 0.
module stopwatch_ctrl_bcd_digit_counter #(
  parameter logic [3:0] MAX_DIGIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  // Carry is combinational so a whole chain of digits rolls over on one edge.
  assign carry = inc && (digit == MAX_DIGIT);

  // Digit register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/pause/lap FSM around a saturating mm:ss BCD counter.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   STATE_IDLE  | cleared, waiting for start_pause
//   STATE_RUN   | counting on tick; lap_reset toggles lap hold
//   STATE_PAUSE | frozen; start_pause resumes, lap_reset clears
//   STATE_DONE  | saturated at LIMIT; only lap_reset (clear) acts
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int                WIDTH = BCD_COUNTER_BITS,
  parameter logic [WIDTH-1:0]  LIMIT = BCD_COUNTER_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start_pause,
  input  logic             lap_reset,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_disp,
  output logic             is_pause,
  output logic             is_restart,
  output logic             is_lap
);

  localparam int DIGITS = WIDTH / 4;

  state_t             state;
  state_t             next_state;
  flags_t             flags_next;
  logic               count_en;
  logic               clr;
  logic               lap_toggle;
  logic               is_lap_next;
  logic [WIDTH-1:0]   lap_q;
  logic [WIDTH-1:0]   lap_q_next;
  logic [WIDTH-1:0]   q_post;
  logic [DIGITS-1:0]  inc;
  logic [DIGITS-1:0]  carry;

  // The LIMIT guard keeps the counter from wrapping even if a tick races DONE.
  assign count_en   = (state == STATE_RUN) && tick && (q != LIMIT);
  assign clr        = ((state == STATE_PAUSE) && lap_reset && !start_pause) ||
                      ((state == STATE_DONE) && lap_reset);
  assign lap_toggle = (state == STATE_RUN) && lap_reset && !start_pause;

  // Digits alternate 9/5 maxima: sec_ones, sec_tens, min_ones, min_tens.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign inc[i] = count_en;
    end else begin : g_chain
      assign inc[i] = carry[i-1];
    end

    stopwatch_ctrl_bcd_digit_counter #(
      .MAX_DIGIT ((i % 2 == 1) ? 4'd5 : 4'd9)
    ) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .clr   (clr),
      .digit (q[4*i +: 4]),
      .carry (carry[i])
    );

    // Value q will hold after this edge; lap capture and DONE detection use it.
    assign q_post[4*i +: 4] = inc[i] ? (carry[i] ? 4'd0 : q[4*i +: 4] + 4'd1)
                                     : q[4*i +: 4];
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STATE_IDLE;
      is_restart <= 1'b0;
      is_pause   <= 1'b0;
      is_lap     <= 1'b0;
      lap_q      <= '0;
    end else begin
      state      <= next_state;
      is_restart <= flags_next.is_restart;
      is_pause   <= flags_next.is_pause;
      is_lap     <= is_lap_next;
      lap_q      <= lap_q_next;
    end
  end

  // Next-state logic; reaching LIMIT takes priority over a coincident pause.
  always_comb begin
    next_state = state;
    unique case (state)
      STATE_IDLE: begin
        if (start_pause) next_state = STATE_RUN;
      end
      STATE_RUN: begin
        if (count_en && (q_post == LIMIT)) next_state = STATE_DONE;
        else if (start_pause)              next_state = STATE_PAUSE;
      end
      STATE_PAUSE: begin
        if (start_pause)    next_state = STATE_RUN;
        else if (lap_reset) next_state = STATE_IDLE;
      end
      STATE_DONE: begin
        if (lap_reset) next_state = STATE_IDLE;
      end
      default: next_state = STATE_IDLE;
    endcase
  end

  // Output logic: flags follow the next state, lap hold toggles or clears.
  always_comb begin
    flags_next  = state_flags(next_state);
    is_lap_next = is_lap;
    lap_q_next  = lap_q;
    if (clr) begin
      is_lap_next = 1'b0;
      lap_q_next  = '0;
    end else if (lap_toggle) begin
      is_lap_next = !is_lap;
      if (!is_lap) lap_q_next = q_post;
    end
  end

  assign q_disp = is_lap ? lap_q : q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: seconds-based reference model feeding a scoreboard.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_pause = 1'b0;
  logic        lap_reset = 1'b0;
  logic [15:0] q;
  logic [15:0] q_disp;
  logic        is_pause;
  logic        is_restart;
  logic        is_lap;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .start_pause (start_pause),
    .lap_reset   (lap_reset),
    .q           (q),
    .q_disp      (q_disp),
    .is_pause    (is_pause),
    .is_restart  (is_restart),
    .is_lap      (is_lap)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] q_disp;
    logic        is_pause;
    logic        is_restart;
    logic        is_lap;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_e;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  mode_e mode;
  int    secs;
  int    lap_secs;
  bit    lap_on;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic void model_reset();
    mode     = M_IDLE;
    secs     = 0;
    lap_secs = 0;
    lap_on   = 1'b0;
  endfunction

  function automatic void model_clear();
    mode     = M_IDLE;
    secs     = 0;
    lap_secs = 0;
    lap_on   = 1'b0;
  endfunction

  function automatic void model_step(input bit tk, input bit sp, input bit lr);
    case (mode)
      M_IDLE: if (sp) mode = M_RUN;
      M_RUN: begin
        if (tk && secs < 3599) secs = secs + 1;
        if (lr && !sp) begin
          lap_on = !lap_on;
          if (lap_on) lap_secs = secs;
        end
        if (tk && secs == 3599) mode = M_DONE;
        else if (sp)            mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (sp)      mode = M_RUN;
        else if (lr) model_clear();
      end
      M_DONE: if (lr) model_clear();
      default: mode = M_IDLE;
    endcase
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.q          = to_bcd(secs);
    e.q_disp     = lap_on ? to_bcd(lap_secs) : e.q;
    e.is_pause   = (mode == M_PAUSE) || (mode == M_DONE);
    e.is_restart = (mode != M_IDLE);
    e.is_lap     = lap_on;
    return e;
  endfunction

  task automatic step(input bit tk, input bit sp, input bit lr);
    @(negedge clk);
    tick        = tk;
    start_pause = sp;
    lap_reset   = lr;
    model_step(tk, sp, lr);
    sb_q.push_back(model_expect());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every clocked cycle out of reset presents a new status word.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({q, q_disp, is_pause, is_restart, is_lap} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t actual q=%h disp=%h p=%b r=%b l=%b required q=%h disp=%h p=%b r=%b l=%b",
                 $time, q, q_disp, is_pause, is_restart, is_lap,
                 e.q, e.q_disp, e.is_pause, e.is_restart, e.is_lap);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_q", {16'd0, q}, 32'h0);
    check("reset_q_disp", {16'd0, q_disp}, 32'h0);
    check("reset_flags", {29'd0, is_restart, is_pause, is_lap}, 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a count; a pulse during reset is lost.
    step(0, 1, 0);
    repeat (12) step(1, 0, 0);
    settle();
    check("pre_reset_q", {16'd0, q}, 32'h0012);
    #1;
    rst_n       = 1'b0;
    tick        = 1'b0;
    start_pause = 1'b0;
    lap_reset   = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    check("mid_reset_q", {16'd0, q}, 32'h0);
    check("mid_reset_flags", {29'd0, is_restart, is_pause, is_lap}, 32'h0);
    start_pause = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_pause = 1'b0;
    rst_n       = 1'b1;
    settle();
    check("pulse_in_reset_lost", {31'd0, is_restart}, 32'h0);

    // Start, count, pause with coincident tick, frozen while paused.
    step(0, 1, 0);
    repeat (70) step(1, 0, 0);
    settle();
    check("run70_q", {16'd0, q}, 32'h0110);
    check("run70_flags", {30'd0, is_restart, is_pause}, 32'h2);
    step(1, 1, 0);
    settle();
    check("pause_tick_q", {16'd0, q}, 32'h0111);
    check("pause_tick_flags", {30'd0, is_restart, is_pause}, 32'h3);
    repeat (5) step(1, 0, 0);
    settle();
    check("pause_frozen_q", {16'd0, q}, 32'h0111);

    // Digit carries.
    step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(1, 0, 0);
    settle();
    check("carry_0059", {16'd0, q}, 32'h0059);
    step(1, 0, 0);
    settle();
    check("carry_0100", {16'd0, q}, 32'h0100);
    repeat (539) step(1, 0, 0);
    settle();
    check("carry_0959", {16'd0, q}, 32'h0959);
    step(1, 0, 0);
    settle();
    check("carry_1000", {16'd0, q}, 32'h1000);

    // Lap hold.
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    repeat (20) step(1, 0, 0);
    step(0, 0, 1);
    settle();
    check("lap_on", {31'd0, is_lap}, 32'h1);
    check("lap_disp_0020", {16'd0, q_disp}, 32'h0020);
    repeat (5) step(1, 0, 0);
    settle();
    check("lap_q_0025", {16'd0, q}, 32'h0025);
    check("lap_disp_held", {16'd0, q_disp}, 32'h0020);
    step(0, 0, 1);
    settle();
    check("lap_off", {31'd0, is_lap}, 32'h0);
    check("lap_release_disp", {16'd0, q_disp}, 32'h0025);

    // Both buttons while paused: resume, no clear.
    step(0, 1, 0);
    step(0, 1, 1);
    settle();
    check("both_pause_q", {16'd0, q}, 32'h0025);
    check("both_pause_flags", {30'd0, is_restart, is_pause}, 32'h2);

    // Saturation at 59:59.
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    repeat (3598) step(1, 0, 0);
    settle();
    check("sat_5958", {16'd0, q}, 32'h5958);
    repeat (3) step(1, 0, 0);
    settle();
    check("sat_5959", {16'd0, q}, 32'h5959);
    check("sat_flags", {30'd0, is_restart, is_pause}, 32'h3);
    step(0, 1, 0);
    settle();
    check("done_sp_ignored", {14'd0, q, is_restart, is_pause}, {14'd0, 16'h5959, 2'b11});
    step(0, 0, 1);
    settle();
    check("done_clear", {14'd0, q, is_restart, is_pause}, 32'h0);

    // Both buttons while done: clear wins.
    step(0, 1, 0);
    repeat (3599) step(1, 0, 0);
    step(0, 1, 1);
    settle();
    check("both_done", {14'd0, q, is_restart, is_pause}, 32'h0);

    // Randomised traffic against the reference model.
    repeat (3000) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    tick        = 1'b0;
    start_pause = 1'b0;
    lap_reset   = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
